// File: rtl/riscv_aes_inv_cipher.sv
// Iterative AES-128 inverse cipher: on-chip expansion to round key 10, then one inverse round per cycle.
// Optional round-key-10 cache, enabled by defining AES_INV_KEY_CACHE_EN.
module riscv_aes_inv_cipher (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_aes_in,
  input  logic [127:0] datain,
  input  logic [127:0] key,
  output logic         busy,
  output logic         start_aes_out,
  output logic [127:0] dataout
);

  typedef enum logic [1:0] {S_IDLE, S_KEYEXP, S_DEC} state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = 8'h00;
    case (x)
      8'h00: y = 8'h52; 8'h01: y = 8'h09; 8'h02: y = 8'h6a; 8'h03: y = 8'hd5; 8'h04: y = 8'h30; 8'h05: y = 8'h36; 8'h06: y = 8'ha5; 8'h07: y = 8'h38;
      8'h08: y = 8'hbf; 8'h09: y = 8'h40; 8'h0a: y = 8'ha3; 8'h0b: y = 8'h9e; 8'h0c: y = 8'h81; 8'h0d: y = 8'hf3; 8'h0e: y = 8'hd7; 8'h0f: y = 8'hfb;
      8'h10: y = 8'h7c; 8'h11: y = 8'he3; 8'h12: y = 8'h39; 8'h13: y = 8'h82; 8'h14: y = 8'h9b; 8'h15: y = 8'h2f; 8'h16: y = 8'hff; 8'h17: y = 8'h87;
      8'h18: y = 8'h34; 8'h19: y = 8'h8e; 8'h1a: y = 8'h43; 8'h1b: y = 8'h44; 8'h1c: y = 8'hc4; 8'h1d: y = 8'hde; 8'h1e: y = 8'he9; 8'h1f: y = 8'hcb;
      8'h20: y = 8'h54; 8'h21: y = 8'h7b; 8'h22: y = 8'h94; 8'h23: y = 8'h32; 8'h24: y = 8'ha6; 8'h25: y = 8'hc2; 8'h26: y = 8'h23; 8'h27: y = 8'h3d;
      8'h28: y = 8'hee; 8'h29: y = 8'h4c; 8'h2a: y = 8'h95; 8'h2b: y = 8'h0b; 8'h2c: y = 8'h42; 8'h2d: y = 8'hfa; 8'h2e: y = 8'hc3; 8'h2f: y = 8'h4e;
      8'h30: y = 8'h08; 8'h31: y = 8'h2e; 8'h32: y = 8'ha1; 8'h33: y = 8'h66; 8'h34: y = 8'h28; 8'h35: y = 8'hd9; 8'h36: y = 8'h24; 8'h37: y = 8'hb2;
      8'h38: y = 8'h76; 8'h39: y = 8'h5b; 8'h3a: y = 8'ha2; 8'h3b: y = 8'h49; 8'h3c: y = 8'h6d; 8'h3d: y = 8'h8b; 8'h3e: y = 8'hd1; 8'h3f: y = 8'h25;
      8'h40: y = 8'h72; 8'h41: y = 8'hf8; 8'h42: y = 8'hf6; 8'h43: y = 8'h64; 8'h44: y = 8'h86; 8'h45: y = 8'h68; 8'h46: y = 8'h98; 8'h47: y = 8'h16;
      8'h48: y = 8'hd4; 8'h49: y = 8'ha4; 8'h4a: y = 8'h5c; 8'h4b: y = 8'hcc; 8'h4c: y = 8'h5d; 8'h4d: y = 8'h65; 8'h4e: y = 8'hb6; 8'h4f: y = 8'h92;
      8'h50: y = 8'h6c; 8'h51: y = 8'h70; 8'h52: y = 8'h48; 8'h53: y = 8'h50; 8'h54: y = 8'hfd; 8'h55: y = 8'hed; 8'h56: y = 8'hb9; 8'h57: y = 8'hda;
      8'h58: y = 8'h5e; 8'h59: y = 8'h15; 8'h5a: y = 8'h46; 8'h5b: y = 8'h57; 8'h5c: y = 8'ha7; 8'h5d: y = 8'h8d; 8'h5e: y = 8'h9d; 8'h5f: y = 8'h84;
      8'h60: y = 8'h90; 8'h61: y = 8'hd8; 8'h62: y = 8'hab; 8'h63: y = 8'h00; 8'h64: y = 8'h8c; 8'h65: y = 8'hbc; 8'h66: y = 8'hd3; 8'h67: y = 8'h0a;
      8'h68: y = 8'hf7; 8'h69: y = 8'he4; 8'h6a: y = 8'h58; 8'h6b: y = 8'h05; 8'h6c: y = 8'hb8; 8'h6d: y = 8'hb3; 8'h6e: y = 8'h45; 8'h6f: y = 8'h06;
      8'h70: y = 8'hd0; 8'h71: y = 8'h2c; 8'h72: y = 8'h1e; 8'h73: y = 8'h8f; 8'h74: y = 8'hca; 8'h75: y = 8'h3f; 8'h76: y = 8'h0f; 8'h77: y = 8'h02;
      8'h78: y = 8'hc1; 8'h79: y = 8'haf; 8'h7a: y = 8'hbd; 8'h7b: y = 8'h03; 8'h7c: y = 8'h01; 8'h7d: y = 8'h13; 8'h7e: y = 8'h8a; 8'h7f: y = 8'h6b;
      8'h80: y = 8'h3a; 8'h81: y = 8'h91; 8'h82: y = 8'h11; 8'h83: y = 8'h41; 8'h84: y = 8'h4f; 8'h85: y = 8'h67; 8'h86: y = 8'hdc; 8'h87: y = 8'hea;
      8'h88: y = 8'h97; 8'h89: y = 8'hf2; 8'h8a: y = 8'hcf; 8'h8b: y = 8'hce; 8'h8c: y = 8'hf0; 8'h8d: y = 8'hb4; 8'h8e: y = 8'he6; 8'h8f: y = 8'h73;
      8'h90: y = 8'h96; 8'h91: y = 8'hac; 8'h92: y = 8'h74; 8'h93: y = 8'h22; 8'h94: y = 8'he7; 8'h95: y = 8'had; 8'h96: y = 8'h35; 8'h97: y = 8'h85;
      8'h98: y = 8'he2; 8'h99: y = 8'hf9; 8'h9a: y = 8'h37; 8'h9b: y = 8'he8; 8'h9c: y = 8'h1c; 8'h9d: y = 8'h75; 8'h9e: y = 8'hdf; 8'h9f: y = 8'h6e;
      8'ha0: y = 8'h47; 8'ha1: y = 8'hf1; 8'ha2: y = 8'h1a; 8'ha3: y = 8'h71; 8'ha4: y = 8'h1d; 8'ha5: y = 8'h29; 8'ha6: y = 8'hc5; 8'ha7: y = 8'h89;
      8'ha8: y = 8'h6f; 8'ha9: y = 8'hb7; 8'haa: y = 8'h62; 8'hab: y = 8'h0e; 8'hac: y = 8'haa; 8'had: y = 8'h18; 8'hae: y = 8'hbe; 8'haf: y = 8'h1b;
      8'hb0: y = 8'hfc; 8'hb1: y = 8'h56; 8'hb2: y = 8'h3e; 8'hb3: y = 8'h4b; 8'hb4: y = 8'hc6; 8'hb5: y = 8'hd2; 8'hb6: y = 8'h79; 8'hb7: y = 8'h20;
      8'hb8: y = 8'h9a; 8'hb9: y = 8'hdb; 8'hba: y = 8'hc0; 8'hbb: y = 8'hfe; 8'hbc: y = 8'h78; 8'hbd: y = 8'hcd; 8'hbe: y = 8'h5a; 8'hbf: y = 8'hf4;
      8'hc0: y = 8'h1f; 8'hc1: y = 8'hdd; 8'hc2: y = 8'ha8; 8'hc3: y = 8'h33; 8'hc4: y = 8'h88; 8'hc5: y = 8'h07; 8'hc6: y = 8'hc7; 8'hc7: y = 8'h31;
      8'hc8: y = 8'hb1; 8'hc9: y = 8'h12; 8'hca: y = 8'h10; 8'hcb: y = 8'h59; 8'hcc: y = 8'h27; 8'hcd: y = 8'h80; 8'hce: y = 8'hec; 8'hcf: y = 8'h5f;
      8'hd0: y = 8'h60; 8'hd1: y = 8'h51; 8'hd2: y = 8'h7f; 8'hd3: y = 8'ha9; 8'hd4: y = 8'h19; 8'hd5: y = 8'hb5; 8'hd6: y = 8'h4a; 8'hd7: y = 8'h0d;
      8'hd8: y = 8'h2d; 8'hd9: y = 8'he5; 8'hda: y = 8'h7a; 8'hdb: y = 8'h9f; 8'hdc: y = 8'h93; 8'hdd: y = 8'hc9; 8'hde: y = 8'h9c; 8'hdf: y = 8'hef;
      8'he0: y = 8'ha0; 8'he1: y = 8'he0; 8'he2: y = 8'h3b; 8'he3: y = 8'h4d; 8'he4: y = 8'hae; 8'he5: y = 8'h2a; 8'he6: y = 8'hf5; 8'he7: y = 8'hb0;
      8'he8: y = 8'hc8; 8'he9: y = 8'heb; 8'hea: y = 8'hbb; 8'heb: y = 8'h3c; 8'hec: y = 8'h83; 8'hed: y = 8'h53; 8'hee: y = 8'h99; 8'hef: y = 8'h61;
      8'hf0: y = 8'h17; 8'hf1: y = 8'h2b; 8'hf2: y = 8'h04; 8'hf3: y = 8'h7e; 8'hf4: y = 8'hba; 8'hf5: y = 8'h77; 8'hf6: y = 8'hd6; 8'hf7: y = 8'h26;
      8'hf8: y = 8'he1; 8'hf9: y = 8'h69; 8'hfa: y = 8'h14; 8'hfb: y = 8'h63; 8'hfc: y = 8'h55; 8'hfd: y = 8'h21; 8'hfe: y = 8'h0c; 8'hff: y = 8'h7d;
    endcase
    return y;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant (0x09/0x0b/0x0d/0x0e) as a sum of doublings.
  function automatic logic [7:0] gf_mul4(input logic [7:0] b, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (m[3] ? x8 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[0] ? b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = rk[127:96] ^ sub_rot(rk[31:0]) ^ {rc, 24'h0};
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = rk[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] key_inv(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = rk[31:0] ^ rk[63:32];
    p2 = rk[63:32] ^ rk[95:64];
    p1 = rk[95:64] ^ rk[127:96];
    p0 = rk[127:96] ^ sub_rot(p3) ^ {rc, 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  // Row r of the output column c comes from input column (c - r) mod 4.
  function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {
        gf_mul4(a0, 4'he) ^ gf_mul4(a1, 4'hb) ^ gf_mul4(a2, 4'hd) ^ gf_mul4(a3, 4'h9),
        gf_mul4(a0, 4'h9) ^ gf_mul4(a1, 4'he) ^ gf_mul4(a2, 4'hb) ^ gf_mul4(a3, 4'hd),
        gf_mul4(a0, 4'hd) ^ gf_mul4(a1, 4'h9) ^ gf_mul4(a2, 4'he) ^ gf_mul4(a3, 4'hb),
        gf_mul4(a0, 4'hb) ^ gf_mul4(a1, 4'hd) ^ gf_mul4(a2, 4'h9) ^ gf_mul4(a3, 4'he)};
    end
    return o;
  endfunction

  state_t         r_state;
  logic [127:0]   r_st, r_rk, r_dataout;
  logic [3:0]     r_rnd;
  logic           r_busy, r_done;

  logic [127:0]   w_rk_next, w_rk_prev, w_ark, w_round;

  assign w_rk_next = key_fwd(r_rk, rcon(r_rnd));
  assign w_rk_prev = key_inv(r_rk, rcon(r_rnd + 4'd1));
  assign w_ark     = inv_sub_shift(r_st) ^ w_rk_prev;
  assign w_round   = (r_rnd == 4'd0) ? w_ark : inv_mix(w_ark);

`ifdef AES_INV_KEY_CACHE_EN
  logic [127:0]   r_key_lat, r_c_tag, r_c_rk;
  logic           r_c_valid;
  logic           w_hit;

  assign w_hit = r_c_valid && (key == r_c_tag);

  // NOTE: tag/key storage has no reset; r_c_valid alone decides whether it is trusted.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && start_aes_in) r_key_lat <= key;
    if (r_state == S_KEYEXP && r_rnd == 4'd10) begin
      r_c_tag <= r_key_lat;
      r_c_rk  <= w_rk_next;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_st      <= '0;
      r_rk      <= '0;
      r_rnd     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dataout <= '0;
`ifdef AES_INV_KEY_CACHE_EN
      r_c_valid <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start_aes_in) begin
          r_busy <= 1'b1;
`ifdef AES_INV_KEY_CACHE_EN
          if (w_hit) begin
            r_st    <= datain ^ r_c_rk;
            r_rk    <= r_c_rk;
            r_rnd   <= 4'd9;
            r_state <= S_DEC;
          end else begin
            r_st    <= datain;
            r_rk    <= key;
            r_rnd   <= 4'd1;
            r_state <= S_KEYEXP;
          end
`else
          r_st    <= datain;
          r_rk    <= key;
          r_rnd   <= 4'd1;
          r_state <= S_KEYEXP;
`endif
        end
        S_KEYEXP: begin
          r_rk <= w_rk_next;
          if (r_rnd == 4'd10) begin
            r_st    <= r_st ^ w_rk_next;
            r_rnd   <= 4'd9;
            r_state <= S_DEC;
`ifdef AES_INV_KEY_CACHE_EN
            r_c_valid <= 1'b1;
`endif
          end else begin
            r_rnd <= r_rnd + 4'd1;
          end
        end
        S_DEC: begin
          r_st <= w_round;
          r_rk <= w_rk_prev;
          if (r_rnd == 4'd0) begin
            r_dataout <= w_round;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_rnd <= r_rnd - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign start_aes_out = r_done;
  assign dataout       = r_dataout;

endmodule

// File: tb/tb_riscv_aes_inv_cipher.sv
// Bench for riscv_aes_inv_cipher: golden vectors, busy/reset corner cases and encrypt-model loopback.
// Expected latencies follow AES_INV_KEY_CACHE_EN when it is defined.
module tb_riscv_aes_inv_cipher;

  logic         clk = 1'b0;
  logic         rst, start_aes_in;
  logic [127:0] datain, key;
  logic         busy, start_aes_out;
  logic [127:0] dataout;

  always #5 clk = ~clk;

  riscv_aes_inv_cipher dut (
    .clk           (clk),
    .rst           (rst),
    .start_aes_in  (start_aes_in),
    .datain        (datain),
    .key           (key),
    .busy          (busy),
    .start_aes_out (start_aes_out),
    .dataout       (dataout)
  );

`ifdef AES_INV_KEY_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  typedef struct {
    logic [127:0] k;
    logic [127:0] ct;
    logic [127:0] pt;
    string        name;
  } vec_t;

  int           n_total = 0;
  int           n_bad   = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   sbox_t[256];
  bit           c_valid = 1'b0;
  logic [127:0] c_tag   = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Encrypt reference: S-box derived from GF inverse + affine map, not from a table.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return (b << 1) ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] y = 8'h01;
    if (x != 8'h00) repeat (254) y = gmul(y, x);
    else y = 8'h00;
    return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] enc_key_step(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w3, t, n0, n1, n2;
    w3 = rk[31:0];
    t  = {sbox_t[w3[23:16]], sbox_t[w3[15:8]], sbox_t[w3[7:0]], sbox_t[w3[31:24]]} ^ {rc, 24'h0};
    n0 = rk[127:96] ^ t;
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    return {n0, n1, n2, w3 ^ n2};
  endfunction

  function automatic logic [127:0] enc_sub_shift(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = sbox_t[s[127-8*(4*((c+r)%4)+r) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] enc_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
    logic [127:0] rk = k;
    logic [127:0] s  = pt ^ k;
    logic [7:0]   rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      rk = enc_key_step(rk, rc);
      rc = xt(rc);
      s  = enc_sub_shift(s);
      if (r != 10) s = enc_mix(s);
      s = s ^ rk;
    end
    return s;
  endfunction

  // Cache model: a start hits only when the previous completed expansion used the same key.
  task automatic predict(input logic [127:0] k, output int lat);
    bit hit;
    hit     = CACHE_EN && c_valid && (k == c_tag);
    c_valid = 1'b1;
    c_tag   = k;
    lat     = hit ? 11 : 21;
  endtask

  task automatic finish_block(input string name, input int lat_in, input int lat_exp);
    int           lat;
    logic [127:0] exp;
    lat = lat_in;
    while (!start_aes_out && lat < 60) begin
      tick();
      lat++;
    end
    check({name, "_done"}, 128'(start_aes_out), 128'd1);
    check({name, "_lat"}, 128'(lat), 128'(lat_exp));
    check({name, "_busy_at_done"}, 128'(busy), 128'd0);
    if (exp_q.size() == 0) begin
      n_total++;
      n_bad++;
      $display("FAIL %s_sb: no expected result queued", name);
    end else begin
      exp = exp_q.pop_front();
      check({name, "_data"}, dataout, exp);
    end
  endtask

  // Returns in the done cycle, so a following call starts back-to-back.
  task automatic run_block(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] pt,
                           input string name);
    int lat_exp;
    predict(k, lat_exp);
    exp_q.push_back(pt);
    key          = k;
    datain       = ct;
    start_aes_in = 1'b1;
    tick();
    start_aes_in = 1'b0;
    check({name, "_busy"}, 128'(busy), 128'd1);
    finish_block(name, 1, lat_exp);
  endtask

  vec_t         vecs[3];
  int           lat, lat_exp, n_done;
  logic [127:0] rk, rpt;

  initial begin
    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734, "fips_b"};
    vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff, "fips_c1"};
    vecs[2] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, "zero_key"};

    for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));

    rst = 1'b1; start_aes_in = 1'b0; datain = '0; key = '0;
    repeat (3) tick();
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(start_aes_out), 128'd0);
    check("rst_dataout", dataout, 128'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) run_block(vecs[i].k, vecs[i].ct, vecs[i].pt, vecs[i].name);

    // A start while busy is ignored; only the first block completes.
    tick();
    predict(vecs[0].k, lat_exp);
    exp_q.push_back(vecs[0].pt);
    key = vecs[0].k; datain = vecs[0].ct; start_aes_in = 1'b1;
    tick();
    start_aes_in = 1'b0;
    lat = 1;
    repeat (4) begin tick(); lat++; end
    check("ign_busy", 128'(busy), 128'd1);
    key = vecs[1].k; datain = vecs[1].ct; start_aes_in = 1'b1;
    tick();
    lat++;
    start_aes_in = 1'b0;
    finish_block("ign", lat, lat_exp);
    tick();
    check("ign_pulse_width", 128'(start_aes_out), 128'd0);
    n_done = 0;
    repeat (30) begin tick(); if (start_aes_out) n_done++; end
    check("ign_extra_done", 128'(n_done), 128'd0);
    check("ign_hold", dataout, vecs[0].pt);

    // Reset 12 cycles into a decrypt aborts it.
    rk  = {$urandom(), $urandom(), $urandom(), $urandom()};
    rpt = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp_q.push_back(rpt);
    key = rk; datain = aes_enc(rk, rpt); start_aes_in = 1'b1;
    tick();
    start_aes_in = 1'b0;
    n_done = 0;
    repeat (12) begin tick(); if (start_aes_out) n_done++; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    c_valid = 1'b0;
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_dataout", dataout, 128'd0);
    check("abort_done", 128'(start_aes_out), 128'd0);
    repeat (25) begin tick(); if (start_aes_out) n_done++; end
    check("abort_no_done", 128'(n_done), 128'd0);
    run_block(vecs[0].k, vecs[0].ct, vecs[0].pt, "after_rst");

    // Same key back-to-back, second start in the done cycle.
    tick();
    run_block(vecs[1].k, vecs[1].ct, vecs[1].pt, "b2b_first");
    run_block(vecs[1].k, vecs[1].ct, vecs[1].pt, "b2b_second");

    // Loopback through the encrypt model; every fourth block reuses the previous key.
    rk = '0;
    for (int i = 0; i < 1000; i++) begin
      if (i % 4 != 3) rk = {$urandom(), $urandom(), $urandom(), $urandom()};
      rpt = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_block(rk, aes_enc(rk, rpt), rpt, "loop");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
